// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake, and counts retired instructions.
module multicycle_control_unit #(
  parameter int D_WIDTH    = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [D_WIDTH-1:0]    instr,
  input  logic                  mem_ready,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  AdrSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUctrl,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t          state_r, state_next_s;
  logic [CNT_W-1:0] instret_r;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic            funct7b5_s;
  logic            unused_instr_s;

  logic            pcwrite_s, irwrite_s, regwrite_s, memwrite_s, memread_s;
  logic            adrsrc_s, illegal_s, retire_s;
  logic [1:0]      alusrca_s, alusrcb_s, resultsrc_s;
  logic [2:0]      immsrc_s;
  logic [3:0]      alu_s;

  assign opcode_s       = instr[6:0];
  assign funct3_s       = instr[14:12];
  assign funct7b5_s     = instr[30];
  assign unused_instr_s = ^{instr[D_WIDTH-1:31], instr[29:15], instr[11:7]};

  // ALU operation for OP / OP-IMM; subtraction only exists in register form
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l,
                                        input logic lu);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = l;
      3'b101:  t = !l;
      3'b110:  t = lu;
      3'b111:  t = !lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next_s = state_r;
    pcwrite_s    = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    memread_s    = 1'b0;
    adrsrc_s     = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    alusrca_s    = 2'b00;
    alusrcb_s    = 2'b00;
    resultsrc_s  = 2'b00;
    immsrc_s     = IMM_I;
    alu_s        = ALU_ADD;

    case (state_r)
      FETCH: begin
        memread_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        if (mem_ready) begin
          irwrite_s    = 1'b1;
          pcwrite_s    = 1'b1;
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while dispatching
        alusrca_s = 2'b01;
        alusrcb_s = 2'b01;
        immsrc_s  = IMM_B;
        case (opcode_s)
          7'd3, 7'd35: state_next_s = MEMADR;
          7'd51:       state_next_s = EXECR;
          7'd19:       state_next_s = EXECI;
          7'd99:       state_next_s = (funct3_s[2:1] == 2'b01) ? TRAP : BRANCH;
          7'd111:      state_next_s = JAL;
          7'd103:      state_next_s = JALR;
          7'd55, 7'd23: state_next_s = UPPER;
          default:     state_next_s = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
        if (opcode_s[5]) begin
          immsrc_s     = IMM_S;
          state_next_s = MEMWRITE;
        end else begin
          immsrc_s     = IMM_I;
          state_next_s = MEMREAD;
        end
      end
      MEMREAD: begin
        adrsrc_s  = 1'b1;
        memread_s = 1'b1;
        if (mem_ready) begin
          state_next_s = MEMWB;
        end else begin
          state_next_s = MEMREAD;
        end
      end
      MEMWB: begin
        resultsrc_s  = 2'b01;
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) begin
          retire_s     = 1'b1;
          state_next_s = FETCH;
        end else begin
          state_next_s = MEMWRITE;
        end
      end
      EXECR: begin
        alusrca_s    = 2'b10;
        alusrcb_s    = 2'b00;
        alu_s        = alu_op(funct3_s, funct7b5_s, 1'b1);
        state_next_s = ALUWB;
      end
      EXECI: begin
        alusrca_s    = 2'b10;
        alusrcb_s    = 2'b01;
        immsrc_s     = IMM_I;
        alu_s        = alu_op(funct3_s, funct7b5_s, 1'b0);
        state_next_s = ALUWB;
      end
      ALUWB: begin
        // For jumps this cycle loads the target into PC instead of writing rd
        resultsrc_s = 2'b00;
        if (opcode_s == 7'd111 || opcode_s == 7'd103) begin
          pcwrite_s = 1'b1;
        end else begin
          regwrite_s = 1'b1;
        end
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      BRANCH: begin
        alusrca_s    = 2'b10;
        alusrcb_s    = 2'b00;
        immsrc_s     = IMM_B;
        alu_s        = ALU_SUB;
        pcwrite_s    = branch_taken(funct3_s, zero, lt, ltu);
        retire_s     = 1'b1;
        state_next_s = FETCH;
      end
      JAL, JALR: begin
        alusrca_s    = 2'b01;
        alusrcb_s    = 2'b10;
        resultsrc_s  = 2'b10;
        regwrite_s   = 1'b1;
        immsrc_s     = (state_r == JAL) ? IMM_J : IMM_I;
        state_next_s = ALUWB;
      end
      UPPER: begin
        immsrc_s  = IMM_U;
        alusrcb_s = 2'b01;
        if (opcode_s == 7'd55) begin
          alu_s = ALU_PASSB;
        end else begin
          alusrca_s = 2'b01;
        end
        state_next_s = ALUWB;
      end
      TRAP: begin
        illegal_s    = 1'b1;
        state_next_s = FETCH;
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // Enables are forced low for the whole time reset is held
  assign PCWrite       = pcwrite_s  & rst_n;
  assign IRWrite       = irwrite_s  & rst_n;
  assign RegWrite      = regwrite_s & rst_n;
  assign MemWrite      = memwrite_s & rst_n;
  assign MemRead       = memread_s  & rst_n;
  assign AdrSrc        = adrsrc_s;
  assign ALUSrcA       = alusrca_s;
  assign ALUSrcB       = alusrcb_s;
  assign ResultSrc     = resultsrc_s;
  assign ImmSrc        = immsrc_s;
  assign ALUctrl       = ALU_CTRL_W'(alu_s);
  assign illegal_instr = illegal_s & rst_n;
  assign instret       = instret_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit; counter narrowed to 3 bits
// so the wrap from 7 to 0 occurs within the instruction sequence.
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready, zero, lt, ltu;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUctrl;
  logic        illegal_instr;
  logic [2:0]  instret;
  logic [5:0]  en_s;
  logic [13:0] sel_s;
  int          checks;
  int          errors;

  multicycle_control_unit #(.D_WIDTH(32), .ALU_CTRL_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .zero(zero), .lt(lt), .ltu(ltu),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .illegal_instr(illegal_instr),
    .instret(instret)
  );

  assign en_s  = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, illegal_instr};
  assign sel_s = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl};

  // enables: {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, illegal_instr}
  localparam logic [5:0] E_F   = 6'b110010;
  localparam logic [5:0] E_FST = 6'b000010;
  localparam logic [5:0] E_0   = 6'b000000;
  localparam logic [5:0] E_RW  = 6'b001000;
  localparam logic [5:0] E_PC  = 6'b100000;
  localparam logic [5:0] E_MR  = 6'b000010;
  localparam logic [5:0] E_MW  = 6'b000100;
  localparam logic [5:0] E_ILL = 6'b000001;
  // selects: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl}
  localparam logic [13:0] S_F    = 14'b0_00_10_10_000_0000;
  localparam logic [13:0] S_DEC  = 14'b0_01_01_00_010_0000;
  localparam logic [13:0] S_LDA  = 14'b0_10_01_00_000_0000;
  localparam logic [13:0] S_STA  = 14'b0_10_01_00_001_0000;
  localparam logic [13:0] S_MEM  = 14'b1_00_00_00_000_0000;
  localparam logic [13:0] S_MWB  = 14'b0_00_00_01_000_0000;
  localparam logic [13:0] S_WB   = 14'b0_00_00_00_000_0000;
  localparam logic [13:0] S_BR   = 14'b0_10_00_00_010_0001;
  localparam logic [13:0] S_SUB  = 14'b0_10_00_00_000_0001;
  localparam logic [13:0] S_SRAI = 14'b0_10_01_00_000_1001;
  localparam logic [13:0] S_ADDI = 14'b0_10_01_00_000_0000;
  localparam logic [13:0] S_JAL  = 14'b0_01_10_10_011_0000;
  localparam logic [13:0] S_LUI  = 14'b0_00_01_00_100_1010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge
  task automatic cyc(input string tag, input logic [5:0] e_en, input logic [13:0] e_sel,
                     input bit do_sel);
    @(negedge clk);
    check({tag, ".en"}, {26'd0, en_s}, {26'd0, e_en});
    if (do_sel) check({tag, ".sel"}, {18'd0, sel_s}, {18'd0, e_sel});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir);
    instr     = ir;
    mem_ready = 1'b1;
    cyc("fetch", E_F, S_F, 1'b1);
    cyc("decode", E_0, S_DEC, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; instr = 32'h0000_0013; mem_ready = 1'b1;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.en", {26'd0, en_s}, 32'd0);
    check("rst.instret", {29'd0, instret}, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    fetch(32'h0050_0093);
    cyc("addi.exec", E_0, S_ADDI, 1'b1);
    cyc("addi.wb", E_RW, S_WB, 1'b1);
    check("addi.instret", {29'd0, instret}, 32'd1);

    // bne taken / not taken, bltu taken, blt not taken
    fetch(32'h0020_9463); zero = 1'b0;
    cyc("bne.taken", E_PC, S_BR, 1'b1);
    fetch(32'h0020_9463); zero = 1'b1;
    cyc("bne.nottaken", E_0, S_BR, 1'b1);
    fetch(32'h0020_E463); zero = 1'b0; ltu = 1'b1;
    cyc("bltu.taken", E_PC, S_BR, 1'b1);
    fetch(32'h0020_C463); lt = 1'b0; ltu = 1'b0;
    cyc("blt.nottaken", E_0, S_BR, 1'b0);
    check("br.instret", {29'd0, instret}, 32'd5);

    // branch funct3=010 traps, no retire
    fetch(32'h0020_A463);
    cyc("br010.trap", E_ILL, S_WB, 1'b1);
    check("br010.instret", {29'd0, instret}, 32'd5);

    // unknown opcode traps, then FETCH stalls on mem_ready=0
    fetch(32'h0000_007F);
    cyc("op7f.trap", E_ILL, S_WB, 1'b1);
    mem_ready = 1'b0;
    cyc("fetch.stall", E_FST, S_F, 1'b1);
    check("op7f.instret", {29'd0, instret}, 32'd5);

    // lw with three wait cycles in MEMREAD: 8 cycles total
    fetch(32'h0000_A083);
    cyc("lw.adr", E_0, S_LDA, 1'b1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.wait", E_MR, S_MEM, 1'b1);
    mem_ready = 1'b1;
    cyc("lw.read", E_MR, S_MEM, 1'b1);
    cyc("lw.wb", E_RW, S_MWB, 1'b1);
    check("lw.instret", {29'd0, instret}, 32'd6);

    // sw x1,0(x2)
    fetch(32'h0011_2023);
    cyc("sw.adr", E_0, S_STA, 1'b1);
    cyc("sw.write", E_MW, S_MEM, 1'b1);
    check("sw.instret", {29'd0, instret}, 32'd7);

    // sub: retirement wraps the 3-bit counter 7 -> 0
    fetch(32'h4020_81B3);
    cyc("sub.exec", E_0, S_SUB, 1'b1);
    cyc("sub.wb", E_RW, S_WB, 1'b1);
    check("wrap.instret", {29'd0, instret}, 32'd0);

    // srai selects sra; addi with instr[30] set stays add
    fetch(32'h4030_D093);
    cyc("srai.exec", E_0, S_SRAI, 1'b1);
    cyc("srai.wb", E_RW, S_WB, 1'b0);
    fetch(32'h4000_0093);
    cyc("addi400.exec", E_0, S_ADDI, 1'b1);
    cyc("addi400.wb", E_RW, S_WB, 1'b0);

    // jal x1,8: link write, then PC load
    fetch(32'h0080_00EF);
    cyc("jal.link", E_RW, S_JAL, 1'b1);
    cyc("jal.pc", E_PC, S_WB, 1'b1);
    check("jal.instret", {29'd0, instret}, 32'd3);

    // lui
    fetch(32'h1234_50B7);
    cyc("lui.upper", E_0, S_LUI, 1'b1);
    cyc("lui.wb", E_RW, S_WB, 1'b0);
    check("lui.instret", {29'd0, instret}, 32'd4);

    // reset asserted during MEMWB
    fetch(32'h0000_A083);
    cyc("lw2.adr", E_0, S_LDA, 1'b0);
    cyc("lw2.read", E_MR, S_MEM, 1'b0);
    @(negedge clk);
    check("lw2.wb", {26'd0, en_s}, {26'd0, E_RW});
    rst_n = 1'b0;
    #1;
    check("rstmid.en", {26'd0, en_s}, 32'd0);
    check("rstmid.instret", {29'd0, instret}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rel.fetch", E_F, S_F, 1'b1);
    cyc("rel.decode", E_0, S_DEC, 1'b1);
    check("rel.instret", {29'd0, instret}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
